bit_deser8: RTL and testbench
=============================

Name: bit_deser8

Overview:
- Sequential inverse of the team's 8:1 bit selector. It accepts one (bit, select index) pair per beat and places the bit at position D[S] of an 8-bit word.
- When all WIDTH positions have been written it presents the assembled word on a valid/ready output.
- It sits on the receive side of any path that serialises a byte through the 8:1 selector, and re-forms the parallel word.

Parameters:
- WIDTH, 8, number of bit positions per word (power of two, 2..64).
- SEL_W, $clog2(WIDTH), width of the select index. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  bit beat present.
- in_bit  input  1  data bit for this beat.
- in_sel  input  SEL_W  destination bit position for in_bit.
- in_ready  output  1  block accepts a beat this cycle.
- clr  input  1  synchronous abort of a partially collected word.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data complete and stable.
- out_ready  input  1  consumer takes out_data.
- bit_mask  output  WIDTH  positions written so far in the current word.
- err_dup  output  1  one-cycle pulse: a position was written twice in one word.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=COLLECT, out_data=0, bit_mask=0, out_valid=0, err_dup=0. in_ready=1 from the first cycle after reset.
- Accept rule: a beat is accepted on a rising edge where in_valid && in_ready && !clr.
- Two states, COLLECT and HOLD.
- COLLECT:
  - in_ready=1, out_valid=0.
  - On accept: out_data[in_sel] <= in_bit and bit_mask[in_sel] <= 1.
  - If bit_mask[in_sel] was already 1: err_dup=1 on the next cycle only. The new bit overwrites the old one, and the mask is unchanged.
  - If the accepted beat makes bit_mask all ones, the next state is HOLD.
- HOLD:
  - in_ready=0, out_valid=1, and out_data is held stable.
  - Beats presented in HOLD are not accepted and have no effect.
  - On out_valid && out_ready: next cycle state=COLLECT, out_valid=0, bit_mask=0.
  - out_data keeps its old contents; positions are overwritten as the new word arrives.
- Latency:
  - out_valid rises on the cycle after the edge that accepted the final missing position.
  - The minimum word period is WIDTH+1 cycles with out_ready tied high: WIDTH beats, then 1 HOLD cycle.
- Ordering: positions may arrive in any order. The word completes on mask coverage, not on beat count.
- clr:
  - In COLLECT: bit_mask <= 0, and any beat in the same cycle is dropped.
  - In HOLD: ignored. A completed word is never discarded by clr.
- Simultaneous duplicate and completion cannot occur, because a duplicate never changes the mask.
- rst mid-word or in HOLD: returns to reset values on the next edge. A pending word is lost with no out_valid.
- in_sel is always in range, since WIDTH is a power of two.
- err_dup never asserts in HOLD.

Decomposition:
- Package deser_pkg holds:
  - typedef enum logic {COLLECT, HOLD} deser_state_t;
  - localparam DESER_WIDTH_DEFAULT = 8.
- No sub-module. A single always_ff for state, data and mask, and a small always_comb for next-state and in_ready/out_valid, fit in one module.

Test Plan:
1. Ordered fill: sel 0..7 with bits of 8'h4B (LSB first), out_ready=1 → out_valid high for exactly 1 cycle, one cycle after the sel=7 beat. out_data=8'h4B, err_dup never asserted.
2. Reverse order with gaps: sel 7..0 with bits of 8'hA5, in_valid toggled 1/0 → out_data=8'hA5. bit_mask steps 80,C0,E0,…,FF before completion.
3. Duplicate: sel0=1, then sel0=0, then sel1..7=0 → err_dup pulses once, 1 cycle after the second sel0 beat. out_data=8'h00. out_valid occurs only after sel7.
4. Backpressure: complete word 8'h3C with out_ready=0 for 5 cycles while in_valid=1, sel0, bit1 → in_ready=0, out_data stays 8'h3C and out_valid stays high throughout. On out_ready=1, out_valid drops on the next cycle and bit_mask=0.
5. clr: write sel0..3 (mask 8'h0F), pulse clr with an in_valid beat on sel4 → bit_mask=0 and the sel4 beat is dropped. A following full 8-beat word of 8'hFF completes normally. clr asserted during HOLD leaves out_valid=1.
6. Reset mid-word: after 5 beats, assert rst for 1 cycle → bit_mask=0, out_data=0, out_valid=0, in_ready=1 on the following cycle. No out_valid appears for the aborted word.

Source files
------------

// File: rtl/bit_deser8_pkg.sv
// Shared types and defaults for the bit deserialiser.
// deser_state_t       : collection state (COLLECT gathers bits, HOLD presents word)
// DESER_WIDTH_DEFAULT : default number of bit positions per word
package deser_pkg;

  typedef enum logic {COLLECT, HOLD} deser_state_t;

  localparam int DESER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bit_deser8_if.sv
// Beat input and word output handshake bundle for bit_deser8.
// in_valid/in_bit/in_sel/in_ready : one (bit, position) beat per accepted cycle
// out_data/out_valid/out_ready    : assembled word, valid/ready handshake
// slave  : deserialiser view; master : producer/consumer view
interface bit_deser8_if
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEFAULT
) ();

  localparam int SEL_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_bit;
  logic [SEL_W-1:0] in_sel;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_valid, in_bit, in_sel, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_valid, in_bit, in_sel, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

// File: rtl/bit_deser8.sv
// Sequential inverse of the 8:1 bit selector: each accepted beat writes
// in_bit into out_data[in_sel]; once every position has been written the word
// is held on out_data with out_valid until the consumer takes it.
// clk      : rising-edge clock
// rst      : synchronous active-high reset
// bus      : beat input / word output handshake (slave modport)
// clr      : abort a partially collected word (ignored while a word is held)
// bit_mask : positions written so far in the current word
// err_dup  : one-cycle pulse after a position was written twice in one word
module bit_deser8
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  bit_deser8_if.slave        bus,
  input  logic               clr,
  output logic [WIDTH-1:0]   bit_mask,
  output logic               err_dup
);

  deser_state_t     state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic             err_q;

  logic             accept;
  logic [WIDTH-1:0] mask_set;
  logic             complete;

  always_comb begin
    bus.in_ready  = (state == COLLECT);
    bus.out_valid = (state == HOLD);
    bus.out_data  = data_q;
    bit_mask      = mask_q;
    err_dup       = err_q;
    accept        = bus.in_valid && (state == COLLECT) && !clr;
    mask_set      = mask_q | (WIDTH'(1) << bus.in_sel);
    // A duplicate leaves the mask unchanged, so it can never complete a word.
    complete      = accept && (mask_set == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      data_q <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (clr) begin
            mask_q <= '0;
          end else if (accept) begin
            data_q[bus.in_sel] <= bus.in_bit;
            mask_q             <= mask_set;
            err_q              <= mask_q[bus.in_sel];
            if (complete) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // data_q is left as is; the next word overwrites it bit by bit.
          if (bus.out_ready) begin
            state  <= COLLECT;
            mask_q <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_deser8.sv
// Scoreboarded directed test for bit_deser8: stimulus pushes expected words
// into a queue, a negedge monitor pops and compares on each output handshake.
module tb_bit_deser8;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [7:0] bit_mask;
  logic       err_dup;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned err_seen;
  logic [7:0]  exp_q[$];

  bit_deser8_if #(.WIDTH(8)) bus ();

  bit_deser8 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clr      (clr),
    .bit_mask (bit_mask),
    .err_dup  (err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {56'd0, bus.out_data}, 64'hDEAD);
      end else begin
        chk("word", {56'd0, bus.out_data}, {56'd0, exp_q.pop_front()});
      end
    end
    if (!rst && err_dup) err_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [2:0] sel, input logic b);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_sel   = sel;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  logic [7:0] w;
  logic [7:0] mask_tab [8];
  int unsigned e0;

  initial begin
    n_cmp = 0; n_bad = 0; err_seen = 0;
    mask_tab = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_sel = '0; bus.out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_mask", {56'd0, bit_mask}, 64'h0);
    chk("rst_data", {56'd0, bus.out_data}, 64'h0);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'h0);
    chk("rst_err", {63'd0, err_dup}, 64'h0);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'h1);

    // 1: ordered fill of 8'h4B
    w = 8'h4B;
    exp_q.push_back(8'h4B);
    for (int unsigned i = 0; i < 8; i++) begin
      send(3'(i), w[i]);
      if (i < 7) chk("t1_valid_early", {63'd0, bus.out_valid}, 64'h0);
    end
    chk("t1_valid_rise", {63'd0, bus.out_valid}, 64'h1);
    idle(1);
    chk("t1_valid_drop", {63'd0, bus.out_valid}, 64'h0);
    chk("t1_mask_clear", {56'd0, bit_mask}, 64'h0);
    chk("t1_no_err", {32'd0, err_seen}, 64'h0);

    // 2: reverse order with gaps, 8'hA5
    w = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int unsigned i = 0; i < 8; i++) begin
      send(3'(7 - i), w[7 - i]);
      chk("t2_mask", {56'd0, bit_mask}, {56'd0, mask_tab[i]});
      if (i < 7) idle(1);
    end
    chk("t2_valid", {63'd0, bus.out_valid}, 64'h1);
    chk("t2_data", {56'd0, bus.out_data}, 64'hA5);
    idle(1);
    chk("t2_mask_clear", {56'd0, bit_mask}, 64'h0);

    // 3: duplicate on position 0
    e0 = err_seen;
    send(3'd0, 1'b1);
    chk("t3_err_first", {63'd0, err_dup}, 64'h0);
    send(3'd0, 1'b0);
    chk("t3_err_pulse", {63'd0, err_dup}, 64'h1);
    chk("t3_mask_dup", {56'd0, bit_mask}, 64'h01);
    exp_q.push_back(8'h00);
    for (int unsigned i = 1; i < 8; i++) begin
      send(3'(i), 1'b0);
      if (i == 1) chk("t3_err_gone", {63'd0, err_dup}, 64'h0);
      if (i == 6) chk("t3_valid_early", {63'd0, bus.out_valid}, 64'h0);
    end
    chk("t3_valid", {63'd0, bus.out_valid}, 64'h1);
    idle(1);
    chk("t3_err_count", {32'd0, err_seen - e0}, 64'h1);

    // 4: backpressure on 8'h3C
    bus.out_ready = 1'b0;
    w = 8'h3C;
    exp_q.push_back(8'h3C);
    for (int unsigned i = 0; i < 8; i++) send(3'(i), w[i]);
    bus.in_valid = 1'b1; bus.in_sel = 3'd0; bus.in_bit = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_ready", {63'd0, bus.in_ready}, 64'h0);
      chk("t4_valid", {63'd0, bus.out_valid}, 64'h1);
      chk("t4_data", {56'd0, bus.out_data}, 64'h3C);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);
    chk("t4_valid_drop", {63'd0, bus.out_valid}, 64'h0);
    chk("t4_mask_clear", {56'd0, bit_mask}, 64'h0);

    // 5: clr mid-word, then clr during HOLD
    for (int unsigned i = 0; i < 4; i++) send(3'(i), 1'b1);
    chk("t5_mask_0f", {56'd0, bit_mask}, 64'h0F);
    clr = 1'b1;
    send(3'd4, 1'b0);
    clr = 1'b0;
    chk("t5_mask_clr", {56'd0, bit_mask}, 64'h0);
    chk("t5_drop", {56'd0, bus.out_data}, 64'h3F);
    bus.out_ready = 1'b0;
    exp_q.push_back(8'hFF);
    for (int unsigned i = 0; i < 8; i++) send(3'(i), 1'b1);
    chk("t5_valid", {63'd0, bus.out_valid}, 64'h1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("t5_hold_clr", {63'd0, bus.out_valid}, 64'h1);
    chk("t5_hold_mask", {56'd0, bit_mask}, 64'hFF);
    bus.out_ready = 1'b1;
    idle(1);
    chk("t5_valid_drop", {63'd0, bus.out_valid}, 64'h0);

    // 6: reset mid-word
    for (int unsigned i = 0; i < 5; i++) send(3'(i), 1'b1);
    chk("t6_mask_pre", {56'd0, bit_mask}, 64'h1F);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_mask", {56'd0, bit_mask}, 64'h0);
    chk("t6_data", {56'd0, bus.out_data}, 64'h0);
    chk("t6_valid", {63'd0, bus.out_valid}, 64'h0);
    chk("t6_ready", {63'd0, bus.in_ready}, 64'h1);
    for (int unsigned i = 5; i < 8; i++) send(3'(i), 1'b1);
    idle(3);
    chk("t6_no_word", {63'd0, bus.out_valid}, 64'h0);
    chk("t6_mask_post", {56'd0, bit_mask}, 64'hE0);

    chk("queue_drained", {32'd0, exp_q.size()}, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
